// File: rtl/seq_pkg.sv
// Shared definitions for the RV32I multi-cycle sequencer: opcodes, states,
// instruction classes, mux encodings and the legal load/store funct3 sets.
package seq_pkg;

    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;
    localparam logic [4:0] OP_OP     = 5'b01100;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU    = 3'd0,
        CL_BRANCH = 3'd1,
        CL_LOAD   = 3'd2,
        CL_STORE  = 3'd3,
        CL_JAL    = 3'd4,
        CL_JALR   = 3'd5
    } opclass_t;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_JALR  = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MDR = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    function automatic logic load_f3_ok(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic store_f3_ok(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_opclass.sv
// Combinational opcode/funct3 decode into an instruction class plus legality.
module seq_opclass
    import seq_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic [2:0] funct3,
    output logic [2:0] cls,
    output logic       legal
);

    always_comb begin
        cls   = CL_ALU;
        legal = 1'b1;
        case (opcode)
            OP_BRANCH: cls = CL_BRANCH;
            OP_LOAD: begin
                cls   = CL_LOAD;
                legal = load_f3_ok(funct3);
            end
            OP_STORE: begin
                cls   = CL_STORE;
                legal = store_f3_ok(funct3);
            end
            OP_JAL:   cls = CL_JAL;
            OP_JALR:  cls = CL_JALR;
            OP_LUI, OP_AUIPC, OP_OPIMM, OP_OP: cls = CL_ALU;
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB over one memory port.
// Optional memory-wait timeout enabled by defining MEMWAIT_TIMEOUT_EN.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             mdr_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             regwrite,
    output logic [1:0]       wb_sel,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

`ifdef MEMWAIT_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t            st, st_nxt;
    logic              halted_q;
    logic [CNT_W-1:0]  instret_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              retire, halt_set;
    logic [2:0]        cls_raw;
    logic              legal;
    opclass_t          cls;

    seq_opclass u_opclass (
        .opcode (opcode),
        .funct3 (funct3),
        .cls    (cls_raw),
        .legal  (legal)
    );
    assign cls = opclass_t'(cls_raw);

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= ST_FETCH;
            instret_q <= '0;
            halted_q  <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            st <= st_nxt;
            if (retire)   instret_q <= instret_q + 1'b1;
            if (halt_set) halted_q  <= 1'b1;
            // Counter restarts on every state change, so it is fresh on FETCH/MEM entry.
            if (st_nxt != st)               wait_cnt <= '0;
            else if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        st_nxt   = st;
        retire   = 1'b0;
        halt_set = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_we    = 1'b0;
        mdr_we   = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = PC_PLUS4;
        regwrite = 1'b0;
        wb_sel   = WB_ALU;
        case (st)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we  = 1'b1;
                    st_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (legal) st_nxt = ST_EXEC;
                else begin
                    st_nxt   = ST_HALT;
                    halt_set = 1'b1;
                end
            end
            ST_EXEC: begin
                if (cls == CL_BRANCH) begin
                    pc_we  = 1'b1;
                    pc_sel = branch_taken ? PC_IMM : PC_PLUS4;
                    retire = 1'b1;
                    st_nxt = ST_FETCH;
                end else if (cls == CL_LOAD || cls == CL_STORE) begin
                    st_nxt = ST_MEM;
                end else begin
                    st_nxt = ST_WB;
                end
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (cls == CL_STORE);
                if (mem_ready) begin
                    if (cls == CL_LOAD) begin
                        mdr_we = 1'b1;
                        st_nxt = ST_WB;
                    end else begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                        st_nxt = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                regwrite = 1'b1;
                pc_we    = 1'b1;
                retire   = 1'b1;
                st_nxt   = ST_FETCH;
                case (cls)
                    CL_LOAD: wb_sel = WB_MDR;
                    CL_JAL: begin
                        wb_sel = WB_PC4;
                        pc_sel = PC_IMM;
                    end
                    CL_JALR: begin
                        wb_sel = WB_PC4;
                        pc_sel = PC_JALR;
                    end
                    default: ;
                endcase
            end
            ST_HALT: ;
            default: st_nxt = ST_FETCH;
        endcase

        // A ready arriving on the limit cycle wins because !mem_ready is required here.
        if (TIMEOUT_EN && mem_req && !mem_ready && wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            st_nxt   = ST_HALT;
            halt_set = 1'b1;
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            addr_sel = 1'b0;
        end

        if (reset) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            addr_sel = 1'b0;
            ir_we    = 1'b0;
            mdr_we   = 1'b0;
            pc_we    = 1'b0;
            pc_sel   = 2'b00;
            regwrite = 1'b0;
            wb_sel   = 2'b00;
        end
    end

    assign state   = reset ? 3'd0 : st;
    assign halted  = reset ? 1'b0 : halted_q;
    assign instret = reset ? '0 : instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: per-instruction phase model
// built from the instruction-class rules, randomized waits and operands.
module tb_multicycle_sequencer;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    opcode;
    logic [2:0]    funct3;
    logic          branch_taken, mem_ready;
    logic          mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we, regwrite, halted;
    logic [1:0]    pc_sel, wb_sel;
    logic [2:0]    state;
    logic [CW-1:0] instret;

    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] m_instret;
    bit            m_halted;

    multicycle_sequencer #(.TIMEOUT_CYCLES(4), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
        .mdr_we(mdr_we), .pc_we(pc_we), .pc_sel(pc_sel), .regwrite(regwrite),
        .wb_sel(wb_sel), .halted(halted), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    logic [14:0] obs;
    assign obs = {state, mem_req, mem_we, addr_sel, ir_we, mdr_we, pc_we,
                  pc_sel, regwrite, wb_sel, halted};

    // Classes: 0 branch, 1 load, 2 store, 3 jal, 4 jalr, 5 alu-like, 6 illegal
    function automatic int cls_of(input logic [4:0] op, input logic [2:0] f3);
        case (op)
            5'b11000: return 0;
            5'b00000: return (f3 == 3 || f3 == 6 || f3 == 7) ? 6 : 1;
            5'b01000: return (f3 <= 2) ? 2 : 6;
            5'b11011: return 3;
            5'b11001: return 4;
            5'b01101, 5'b00101, 5'b00100, 5'b01100: return 5;
            default:  return 6;
        endcase
    endfunction

    // Expected visible outputs for one cycle in phase ph (0..5 = FETCH..HALT).
    function automatic logic [14:0] exp_out(input int ph, input int cls, input bit rdy,
                                            input bit tk, input bit hlt);
        logic req, we, as, irw, mdw, pcw, rw;
        logic [1:0] pcs, wbs;
        {req, we, as, irw, mdw, pcw, rw} = '0;
        pcs = 2'b00; wbs = 2'b00;
        case (ph)
            0: begin req = 1; irw = rdy; end
            2: if (cls == 0) begin pcw = 1; pcs = tk ? 2'b01 : 2'b00; end
            3: begin
                req = 1; as = 1; we = (cls == 2);
                if (rdy) begin
                    if (cls == 1) mdw = 1;
                    else          pcw = 1;
                end
            end
            4: begin
                rw = 1; pcw = 1;
                wbs = (cls == 1) ? 2'b01 : (cls == 3 || cls == 4) ? 2'b10 : 2'b00;
                pcs = (cls == 3) ? 2'b01 : (cls == 4) ? 2'b10 : 2'b00;
            end
            default: ;
        endcase
        return {3'(ph), req, we, as, irw, mdw, pcw, pcs, rw, wbs, hlt};
    endfunction

    // Runs one instruction cycle-by-cycle; abort_at asserts reset on that cycle index.
    task automatic run_instr(input string name, input logic [4:0] op, input logic [2:0] f3,
                             input int fw, input int mw, input bit tk, input int abort_at);
        int ph[$];
        bit rd[$];
        int cls;
        logic [14:0] e;
        cls = cls_of(op, f3);
        for (int i = 0; i < fw; i++) begin ph.push_back(0); rd.push_back(0); end
        ph.push_back(0); rd.push_back(1);
        ph.push_back(1); rd.push_back(1'($urandom));
        if (cls == 6) begin
            for (int i = 0; i < 3; i++) begin ph.push_back(5); rd.push_back(1'($urandom)); end
        end else begin
            ph.push_back(2); rd.push_back(1'($urandom));
            if (cls == 1 || cls == 2) begin
                for (int i = 0; i < mw; i++) begin ph.push_back(3); rd.push_back(0); end
                ph.push_back(3); rd.push_back(1);
            end
            if (cls != 0 && cls != 2) begin ph.push_back(4); rd.push_back(1'($urandom)); end
        end
        opcode = op;
        funct3 = f3;
        for (int i = 0; i < ph.size(); i++) begin
            mem_ready    = rd[i];
            branch_taken = (ph[i] == 2) ? tk : 1'($urandom);
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                checks++;
                if (obs !== 15'd0 || instret !== '0) begin
                    errors++;
                    $display("FAIL %s reset_mid cyc %0d got %h/%0d exp 0/0", name, i, obs, instret);
                end
                @(negedge clk);
                reset = 1'b0;
                m_instret = '0;
                m_halted = 0;
                return;
            end
            #1;
            e = exp_out(ph[i], cls, rd[i], tk, m_halted);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s outputs cyc %0d got %h exp %h", name, i, obs, e);
            end
            checks++;
            if (instret !== m_instret) begin
                errors++;
                $display("FAIL %s instret cyc %0d got %0d exp %0d", name, i, instret, m_instret);
            end
            @(negedge clk);
            if (cls == 6 && ph[i] == 1) m_halted = 1;
            if (cls != 6 && i == ph.size() - 1) m_instret = m_instret + 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (obs !== 15'd0 || instret !== '0) begin
            errors++;
            $display("FAIL reset_hold got %h/%0d exp 0/0", obs, instret);
        end
        @(negedge clk);
        #1;
        checks++;
        if (obs !== 15'd0 || instret !== '0) begin
            errors++;
            $display("FAIL reset_state got %h/%0d exp 0/0", obs, instret);
        end
        reset = 1'b0;
        m_instret = '0;
        m_halted = 0;
    endtask

    task automatic test_alu();
        run_instr("add", 5'b01100, 3'b000, 0, 0, 0, -1);
        run_instr("lui", 5'b01101, 3'b101, 1, 0, 0, -1);
    endtask

    task automatic test_load_wait();
        run_instr("lw_wait", 5'b00000, 3'b010, 0, 2, 0, -1);
    endtask

    task automatic test_branch();
        run_instr("beq_taken", 5'b11000, 3'b000, 0, 0, 1, -1);
        run_instr("beq_not", 5'b11000, 3'b000, 0, 0, 0, -1);
    endtask

    task automatic test_jalr_store();
        run_instr("jalr", 5'b11001, 3'b000, 0, 0, 0, -1);
        run_instr("jal", 5'b11011, 3'b000, 0, 0, 0, -1);
        run_instr("sw", 5'b01000, 3'b010, 0, 1, 0, -1);
    endtask

    task automatic test_illegal();
        run_instr("illegal_op", 5'b11111, 3'b000, 0, 0, 0, -1);
        test_reset();
        run_instr("after_reset", 5'b00100, 3'b000, 0, 0, 0, -1);
        run_instr("load_f3_011", 5'b00000, 3'b011, 0, 0, 0, -1);
        test_reset();
        run_instr("store_f3_100", 5'b01000, 3'b100, 0, 0, 0, -1);
        test_reset();
    endtask

    task automatic test_reset_mid_mem();
        run_instr("lw_abort", 5'b00000, 3'b010, 0, 3, 0, 4);
        run_instr("after_abort", 5'b01100, 3'b000, 0, 0, 0, -1);
    endtask

    task automatic test_random();
        logic [4:0] ops [9] = '{5'b11000, 5'b00000, 5'b01000, 5'b01101, 5'b00101,
                                5'b11011, 5'b11001, 5'b00100, 5'b01100};
        logic [2:0] ldf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [4:0] op;
        logic [2:0] f3;
        for (int n = 0; n < 30; n++) begin
            op = ops[$urandom_range(0, 8)];
            if (op == 5'b00000)      f3 = ldf[$urandom_range(0, 4)];
            else if (op == 5'b01000) f3 = 3'($urandom_range(0, 2));
            else                     f3 = 3'($urandom);
            run_instr("random", op, f3, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom), -1);
        end
    endtask

`ifdef MEMWAIT_TIMEOUT_EN
    task automatic test_timeout();
        logic [14:0] e;
        opcode = 5'b01100;
        funct3 = 3'b000;
        for (int i = 0; i < 6; i++) begin
            mem_ready = (i < 4) ? 1'b0 : 1'($urandom);
            #1;
            e = exp_out((i < 3) ? 0 : (i == 3) ? 7 : 5, 5, 0, 0, m_halted);
            if (i == 3) e = {3'd0, 12'd0};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL timeout cyc %0d got %h exp %h", i, obs, e);
            end
            @(negedge clk);
            if (i == 3) m_halted = 1;
        end
        test_reset();
        run_instr("ready_at_limit_fetch", 5'b01100, 3'b000, 3, 0, 0, -1);
        run_instr("ready_at_limit_mem", 5'b00000, 3'b000, 0, 3, 0, -1);
    endtask
`endif

    initial begin
        reset = 1'b1;
        opcode = '0;
        funct3 = '0;
        branch_taken = 1'b0;
        mem_ready = 1'b0;
        m_instret = '0;
        m_halted = 0;
        @(negedge clk);
        test_reset();
        test_alu();
        test_load_wait();
        test_branch();
        test_jalr_store();
        test_illegal();
        test_reset_mid_mem();
        test_random();
`ifdef MEMWAIT_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the RV32I datapath. Sequences one instruction at a time through FETCH, DECODE, EXEC, MEM and WB over a single shared memory port.
- Decodes opcode (instr[6:2]) and funct3 in DECODE. Drives PC, IR, MDR, register-file and memory enables; handshakes with memory via req/ready.
- Sits between the instruction register and the datapath, replacing the single-cycle combinational control decode.

Parameters:
- TIMEOUT_CYCLES, 15, maximum wait cycles for mem_ready before fault (used only with the optional feature).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  5  instr[6:2] from IR; valid from DECODE onward.
- funct3  in  3  instr[14:12] from IR.
- branch_taken  in  1  ALU compare result; sampled in EXEC.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe; valid only while mem_req=1.
- addr_sel  out  1  memory address source: 0=PC, 1=ALU result.
- ir_we  out  1  latch instruction register.
- mdr_we  out  1  latch memory data register.
- pc_we  out  1  update PC.
- pc_sel  out  2  next-PC source: 00=PC+4, 01=PC+imm, 10=(rs1+imm)&~1.
- regwrite  out  1  register-file write enable.
- wb_sel  out  2  writeback source: 00=ALU, 01=MDR, 10=PC+4.
- halted  out  1  sticky illegal-instruction or fault flag.
- state  out  3  current state, for debug.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. State, instret and halted are registered. All other outputs are decoded combinationally from state, opcode, funct3, branch_taken and mem_ready.
- Reset: state=FETCH, instret=0, halted=0. While reset=1, every output is forced to 0.
  - Reset asserted mid-access drops mem_req on the same cycle. No write completes during reset.
- FETCH: mem_req=1, addr_sel=0, mem_we=0.
  - mem_ready=1: ir_we=1, go to DECODE.
  - Otherwise stay; mem_req stays high and addresses stay stable.
- DECODE: one cycle, no enables asserted.
  - Legal opcodes: 11000, 00000, 01000, 01101, 00101, 11011, 11001, 00100, 01100.
  - Load (00000) with funct3 outside {000,001,010,100,101} is illegal.
  - Store (01000) with funct3 outside {000,001,010} is illegal.
  - Illegal: go to HALT and set halted=1. Otherwise go to EXEC.
- EXEC:
  - Branch: pc_we=1, pc_sel = branch_taken ? 01 : 00, instret+1, go to FETCH.
  - Load or store: go to MEM.
  - All other opcodes: go to WB.
- MEM: mem_req=1, addr_sel=1, mem_we = (opcode==store). Wait for mem_ready.
  - Load: mdr_we=1, go to WB.
  - Store: pc_we=1, pc_sel=00, instret+1, go to FETCH.
- WB: regwrite=1, pc_we=1, instret+1, go to FETCH.
  - Load: wb_sel=01.
  - JAL: wb_sel=10, pc_sel=01.
  - JALR: wb_sel=10, pc_sel=10.
  - All others: wb_sel=00, pc_sel=00.
- HALT: all enables 0. Exits only via reset.
- mem_ready: a same-cycle response (zero-wait memory) is legal. mem_ready outside FETCH/MEM is ignored.
- Latency with zero-wait memory:
  - Branch: 3 cycles.
  - Store and ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - Load: 5 cycles.
  - Each wait cycle adds 1.
- instret wraps modulo 2^CNT_W.

Optional Feature:
- Macro: MEMWAIT_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to FETCH or MEM and increments each cycle mem_req=1 with mem_ready=0.
  - When the counter reaches TIMEOUT_CYCLES without mem_ready, go to HALT, set halted=1 and drop mem_req.
  - mem_ready arriving on the same cycle the limit is reached wins; the access completes normally.
- Not defined: waits are unbounded, and halted is set only by an illegal instruction.

Decomposition:
- Shared package (seq_pkg):
  - opcode constants for the 9 legal instruction classes;
  - state enum;
  - pc_sel and wb_sel encodings;
  - legal load/store funct3 sets.
- One natural sub-module: seq_opclass. Purely combinational opcode/funct3 to {class, legal} decode, used by DECODE, EXEC, MEM and WB.

Test Plan:
- Reset, then add (opcode 01100) with mem_ready tied 1: states 0,1,2,4,0; regwrite=1 and wb_sel=00 only in WB; instret=1 after 4 cycles.
- Load lw (00000, funct3=010), mem_ready low for 2 cycles in MEM: mem_req, addr_sel=1 held 3 cycles; mdr_we on ready; WB with wb_sel=01; 7 cycles total.
- Branch beq (11000) with branch_taken=1, then =0: pc_we in EXEC with pc_sel=01, then 00; no regwrite; 3 cycles each.
- JALR (11001): WB shows regwrite=1, wb_sel=10, pc_sel=10. Store sw (01000, funct3=010): mem_we=1 in MEM, no regwrite.
- Illegal opcode 11111, and load funct3=011: HALT after DECODE, halted=1, no further mem_req; reset returns to FETCH with instret=0.
- With MEMWAIT_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ready held 0 in FETCH: HALT after 4 wait cycles, halted=1. Reset asserted during a MEM wait: mem_req=0 on the same cycle, FETCH next.
